// File: rtl/secded_scrub_ctrl.sv
// Background scrubber: walks the SECDED array, routes each word through an
// external one-register decoder, writes back single-bit corrections and logs double errors.
module secded_scrub_ctrl #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10,
  parameter int INTERVAL_W = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [INTERVAL_W-1:0] interval,
  input  logic                  clr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [71:0]           mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [71:0]           mem_rdata,
  output logic [71:0]           dec_data_in,
  input  logic [71:0]           dec_data_out,
  input  logic                  dec_single,
  input  logic                  dec_double,
  output logic [CNT_W-1:0]      sec_count,
  output logic [CNT_W-1:0]      ded_count,
  output logic                  ded_flag,
  output logic [ADDR_W-1:0]     ded_addr,
  output logic                  pass_done,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_READ, S_RDATA, S_DECODE, S_EVAL, S_WRITE, S_NEXT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [INTERVAL_W-1:0] ivl_q, ivl_d;
  logic [71:0]           word_q, word_d;
  logic [71:0]           wdata_q, wdata_d;
  logic [CNT_W-1:0]      sec_q, sec_d;
  logic [CNT_W-1:0]      ded_q, ded_d;
  logic                  dflag_q, dflag_d;
  logic [ADDR_W-1:0]     daddr_q, daddr_d;
  logic [INTERVAL_W:0]   ivl_next;
  logic                  wait_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // WAIT always lasts at least one cycle; interval=N gives N cycles for N>=1.
  assign ivl_next  = {1'b0, ivl_q} + (INTERVAL_W+1)'(1);
  assign wait_done = (ivl_next >= {1'b0, interval});

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ivl_d     = ivl_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    sec_d     = sec_q;
    ded_d     = ded_q;
    dflag_d   = dflag_q;
    daddr_d   = daddr_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    pass_done = 1'b0;
    case (state_q)
      S_IDLE:   if (enable) state_d = S_WAIT;
      S_WAIT: begin
        if (wait_done) state_d = S_READ;
        else           ivl_d   = ivl_next[INTERVAL_W-1:0];
      end
      S_READ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (mem_rvalid) begin
          word_d  = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EVAL;
      S_EVAL: begin
        if (dec_single) begin
          wdata_d = dec_data_out;
          sec_d   = sat_inc(sec_q);
          state_d = S_WRITE;
        end else begin
          if (dec_double) begin
            ded_d   = sat_inc(ded_q);
            dflag_d = 1'b1;
            daddr_d = addr_q;
          end
          state_d = S_NEXT;
        end
      end
      S_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_gnt) state_d = S_NEXT;
      end
      S_NEXT: begin
        ivl_d     = '0;
        pass_done = (addr_q == LAST_ADDR);
        addr_d    = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
        state_d   = enable ? S_WAIT : S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
    // A clear overrides any increment landing in the same cycle.
    if (clr) begin
      sec_d   = '0;
      ded_d   = '0;
      dflag_d = 1'b0;
      daddr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ivl_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      sec_q   <= '0;
      ded_q   <= '0;
      dflag_q <= 1'b0;
      daddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ivl_q   <= ivl_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      sec_q   <= sec_d;
      ded_q   <= ded_d;
      dflag_q <= dflag_d;
      daddr_q <= daddr_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign dec_data_in = word_q;
  assign sec_count   = sec_q;
  assign ded_count   = ded_q;
  assign ded_flag    = dflag_q;
  assign ded_addr    = daddr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_secded_scrub_ctrl.sv
// Scoreboard bench: memory/arbiter and decoder models, expected accesses queued per run.
module tb_secded_scrub_ctrl;
  localparam int DEPTH = 4, ADDR_W = 2, INTERVAL_W = 4, CNT_W = 2;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b0, clr = 1'b0;
  logic [INTERVAL_W-1:0] interval = '0;
  logic mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [71:0] mem_wdata;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [71:0] mem_rdata = '0;
  logic [71:0] dec_data_in;
  logic [71:0] dec_data_out = '0;
  logic dec_single = 1'b0, dec_double = 1'b0;
  logic [CNT_W-1:0] sec_count, ded_count;
  logic ded_flag;
  logic [ADDR_W-1:0] ded_addr;
  logic pass_done, busy;

  secded_scrub_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INTERVAL_W(INTERVAL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .interval(interval), .clr(clr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dec_data_in(dec_data_in), .dec_data_out(dec_data_out),
    .dec_single(dec_single), .dec_double(dec_double),
    .sec_count(sec_count), .ded_count(ded_count), .ded_flag(ded_flag), .ded_addr(ded_addr),
    .pass_done(pass_done), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { int kind; int addr; logic [71:0] data; } exp_t; // kind 0 read, 1 write, 2 pass
  exp_t q[$];
  int n_tests = 0, n_fail = 0, cyc = 0, n_reads = 0;
  int rd_cyc[$], pd_cyc[$];
  logic [71:0] golden [DEPTH];
  logic [71:0] mem    [DEPTH];
  logic [71:0] err    [DEPTH];
  int m_addr = 0, m_sec = 0, m_ded = 0, m_daddr = 0;
  bit m_flag = 0;
  bit rnd_mode = 0;
  int hold_rd = 0, hold_wr = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory + arbiter: grant decided 1 time unit after the edge, applied at the next edge.
  bit in_req = 0, acc = 0, acc_we = 0;
  int hold_cnt = 0, cur_hold = 0, rv_cnt = 0, rv_addr = 0, acc_addr = 0;
  logic [71:0] acc_wd = '0;
  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b0;
    if (rst) begin
      in_req = 0; acc = 0; rv_cnt = 0;
    end else begin
      if (acc) begin
        if (acc_we) mem[acc_addr] = acc_wd;
        else begin rv_cnt = rnd_mode ? int'($urandom_range(1, 3)) : 1; rv_addr = acc_addr; end
        acc = 0;
      end
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin mem_rvalid = 1'b1; mem_rdata = mem[rv_addr]; end
      end
      if (mem_req) begin
        if (!in_req) begin
          in_req = 1; hold_cnt = 0;
          cur_hold = rnd_mode ? int'($urandom_range(0, 3)) : (mem_we ? hold_wr : hold_rd);
        end
        if (hold_cnt >= cur_hold) begin
          mem_gnt = 1'b1; acc = 1; acc_we = mem_we; acc_addr = int'(mem_addr); acc_wd = mem_wdata;
          in_req = 0;
        end else hold_cnt++;
      end else in_req = 0;
    end
  end

  // Decoder: registers its input, classifies by Hamming distance to the golden contents.
  logic [71:0] dec_cap = '0;
  int dd;
  always @(negedge clk) dec_cap = dec_data_in;
  always @(posedge clk) begin
    #1;
    dec_single = 1'b0; dec_double = 1'b0; dec_data_out = dec_cap;
    for (int i = 0; i < DEPTH; i++) begin
      dd = $countones(dec_cap ^ golden[i]);
      if (dd == 1) begin dec_single = 1'b1; dec_data_out = golden[i]; end
      else if (dd == 2) dec_double = 1'b1;
    end
  end

  // Monitor: request stability, accepted accesses and pass pulses against the queue.
  bit trk = 0;
  logic trk_we;
  logic [ADDR_W-1:0] trk_addr;
  logic [71:0] trk_wd;
  exp_t e;
  always @(negedge clk) begin
    if (rst) trk = 0;
    else begin
      if (mem_req) begin
        if (trk) begin
          chk("hold_we", 72'(mem_we), 72'(trk_we));
          chk("hold_addr", 72'(mem_addr), 72'(trk_addr));
          chk("hold_wdata", mem_wdata, trk_wd);
        end else begin
          trk = 1; trk_we = mem_we; trk_addr = mem_addr; trk_wd = mem_wdata;
        end
        if (mem_gnt) begin
          trk = 0;
          if (q.size() == 0) fail_now("unexpected_access");
          else begin
            e = q.pop_front();
            chk("acc_kind", 72'(mem_we), 72'(e.kind));
            chk("acc_addr", 72'(mem_addr), 72'(e.addr));
            if (mem_we) chk("acc_wdata", mem_wdata, e.data);
          end
          if (!mem_we) begin n_reads++; rd_cyc.push_back(cyc); end
        end
      end else trk = 0;
      if (pass_done) begin
        pd_cyc.push_back(cyc);
        if (q.size() == 0) fail_now("unexpected_pass_done");
        else begin
          e = q.pop_front();
          chk("pass_kind", 72'(2), 72'(e.kind));
          chk("pass_addr", 72'(mem_addr), 72'(DEPTH - 1));
        end
      end
    end
  end

  task automatic push_exp(input int kind, input int addr, input logic [71:0] data);
    exp_t x;
    x.kind = kind; x.addr = addr; x.data = data;
    q.push_back(x);
  endtask

  task automatic inject(input int a, input int b0, input int b1);
    err[a] = '0;
    err[a][b0] = 1'b1;
    if (b1 >= 0) err[a][b1] = 1'b1;
    mem[a] = golden[a] ^ err[a];
  endtask

  task automatic model_clear();
    m_sec = 0; m_ded = 0; m_flag = 0; m_daddr = 0;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_sec"}, 72'(sec_count), 72'(m_sec));
    chk({tag, "_ded"}, 72'(ded_count), 72'(m_ded));
    chk({tag, "_flag"}, 72'(ded_flag), 72'(m_flag));
    chk({tag, "_daddr"}, 72'(ded_addr), 72'(m_daddr));
  endtask

  // Scrub n words; clr is pulsed during the EVAL cycle of word clr_at (needs rvalid after 1 cycle).
  task automatic run_words(input int n, input int clr_at, input string tag);
    int start, seen, clr_cd;
    bit done;
    for (int k = 1; k <= n; k++) begin
      int pc;
      pc = $countones(err[m_addr]);
      push_exp(0, m_addr, '0);
      if (pc == 1) begin
        push_exp(1, m_addr, golden[m_addr]);
        err[m_addr] = '0;
        if (m_sec < CMAX) m_sec++;
      end else if (pc == 2) begin
        if (m_ded < CMAX) m_ded++;
        m_flag = 1; m_daddr = m_addr;
      end
      if (k == clr_at) model_clear();
      if (m_addr == DEPTH - 1) push_exp(2, m_addr, '0);
      m_addr = (m_addr + 1) % DEPTH;
    end
    start = n_reads; seen = 0; clr_cd = -1; done = 0;
    enable = 1'b1;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk); #2;
      clr = 1'b0;
      if (clr_cd == 0) clr = 1'b1;
      if (clr_cd >= 0) clr_cd--;
      if (n_reads - start != seen) begin
        seen = n_reads - start;
        if (seen == clr_at) clr_cd = 1;
        if (seen >= n) enable = 1'b0;
      end
      if (seen >= n && !busy && q.size() == 0 && clr_cd < 0 && !clr) done = 1;
    end
    enable = 1'b0;
    clr = 1'b0;
    if (!done) begin fail_now({tag, "_timeout"}); q.delete(); end
    chk({tag, "_reads"}, 72'(n_reads - start), 72'(n));
    check_counts(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    for (int i = 0; i < DEPTH; i++) begin
      golden[i] = {$urandom, $urandom, 8'($urandom)};
      mem[i] = golden[i];
      err[i] = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_req", 72'(mem_req), 72'(0));
    chk("rst_we", 72'(mem_we), 72'(0));
    chk("rst_addr", 72'(mem_addr), 72'(0));
    chk("rst_wdata", mem_wdata, 72'(0));
    chk("rst_decin", dec_data_in, 72'(0));
    chk("rst_pass", 72'(pass_done), 72'(0));
    check_counts("rst");
    rst = 1'b0;
    @(posedge clk); #2;

    // Clean passes, immediate grant and rvalid.
    rd_cyc.delete(); pd_cyc.delete();
    run_words(12, 0, "clean");
    for (int i = 0; i + 1 < rd_cyc.size(); i += 3)
      chk("clean_read_gap", 72'(rd_cyc[i+1] - rd_cyc[i]), 72'(6));
    chk("clean_pass_cnt", 72'(pd_cyc.size()), 72'(3));
    for (int i = 0; i + 1 < pd_cyc.size(); i++)
      chk("clean_pass_gap", 72'(pd_cyc[i+1] - pd_cyc[i]), 72'(24));

    inject(2, 5, -1);
    run_words(4, 0, "single");
    run_words(4, 0, "single_fixed");

    inject(1, 3, 40);
    run_words(4, 0, "double");
    mem[1] = golden[1]; err[1] = '0;
    clr = 1'b1; @(posedge clk); #2; clr = 1'b0;
    model_clear();
    @(posedge clk); #2;
    check_counts("clr_idle");

    for (int i = 0; i < DEPTH; i++) inject(i, int'($urandom_range(0, 71)), -1);
    run_words(4, 0, "sat_a");
    inject(0, 17, -1); inject(1, 70, -1);
    run_words(2, 0, "sat_b");
    chk("sat_value", 72'(sec_count), 72'(3));

    inject(m_addr, 9, -1);
    run_words(1, 1, "clr_eval");
    chk("clr_eval_zero", 72'(sec_count), 72'(0));

    hold_rd = 7; hold_wr = 7;
    inject((m_addr + 1) % DEPTH, 33, -1);
    run_words(4, 0, "arb_hold");
    hold_rd = 0; hold_wr = 0;

    interval = 4'd3;
    rd_cyc.delete();
    run_words(5, 0, "interval3");
    for (int i = 0; i + 1 < rd_cyc.size(); i++)
      chk("interval3_gap", 72'(rd_cyc[i+1] - rd_cyc[i]), 72'(8));

    rnd_mode = 1;
    for (int r = 0; r < 8; r++) begin
      interval = 4'($urandom_range(0, 2));
      for (int i = 0; i < DEPTH; i++) begin
        int sel;
        sel = int'($urandom_range(0, 99));
        b0 = int'($urandom_range(0, 71));
        if (sel < 30) inject(i, b0, -1);
        else if (sel < 45) inject(i, b0, (b0 + 1 + int'($urandom_range(0, 70))) % 72);
      end
      run_words(int'($urandom_range(1, 6)), 0, "random");
    end

    // Reset while a write-back is held off by the arbiter.
    rnd_mode = 0; interval = '0; hold_rd = 0; hold_wr = 40;
    inject(m_addr, 60, -1);
    push_exp(0, m_addr, '0);
    push_exp(1, m_addr, golden[m_addr]);
    enable = 1'b1;
    begin
      bit seen_wr;
      seen_wr = 0;
      for (int c = 0; c < 200 && !seen_wr; c++) begin
        @(posedge clk); #2;
        if (mem_req && mem_we) seen_wr = 1;
      end
      if (!seen_wr) fail_now("rst_wr_timeout");
    end
    enable = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    chk("rstw_req", 72'(mem_req), 72'(0));
    chk("rstw_we", 72'(mem_we), 72'(0));
    chk("rstw_busy", 72'(busy), 72'(0));
    chk("rstw_addr", 72'(mem_addr), 72'(0));
    chk("rstw_wdata", mem_wdata, 72'(0));
    chk("rstw_decin", dec_data_in, 72'(0));
    chk("rstw_pass", 72'(pass_done), 72'(0));
    model_clear();
    check_counts("rstw");
    @(posedge clk); #2;
    rst = 1'b0;
    q.delete();
    m_addr = 0; hold_wr = 0; rnd_mode = 1;
    @(posedge clk); #2;
    run_words(4, 0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/secded_scrub_ctrl.md
# secded_scrub_ctrl

Background memory scrubber for the 72-bit SECDED-protected array. It walks every address, reads each codeword and routes it through the sequential SECDED decoder. It writes the corrected word back on a single-bit error and logs uncorrectable double-bit errors. It sits between the memory arbiter (as the lowest-priority requester) and one dedicated decoder instance.

## Interface
- `DEPTH`, 1024: number of 72-bit words scrubbed per pass.
- `ADDR_W`, 10: address width; `2**ADDR_W >= DEPTH`.
- `INTERVAL_W`, 16: width of the inter-word idle-interval setting.
- `CNT_W`, 16: width of the error counters.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  scrubbing enabled.
- `interval`  in  INTERVAL_W  idle cycles inserted before each word read.
- `clr`  in  1  synchronous clear of counters and error log.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`.
- `mem_addr`  out  ADDR_W  access address.
- `mem_wdata`  out  72  write codeword.
- `mem_gnt`  in  1  arbiter grant; the access is accepted in a cycle with `mem_req & mem_gnt`.
- `mem_rvalid`  in  1  read data valid, arriving one or more cycles after the read grant.
- `mem_rdata`  in  72  read codeword.
- `dec_data_in`  out  72  codeword presented to the decoder.
- `dec_data_out`  in  72  corrected codeword from the decoder.
- `dec_single`  in  1  decoder single-error flag.
- `dec_double`  in  1  decoder double-error flag.
- `sec_count`  out  CNT_W  corrected-error count, saturating.
- `ded_count`  out  CNT_W  uncorrectable-error count, saturating.
- `ded_flag`  out  1  sticky: at least one double error since the last clear or reset.
- `ded_addr`  out  ADDR_W  address of the most recent double error.
- `pass_done`  out  1  one-cycle pulse when the last address completes.
- `busy`  out  1  state is not IDLE.

## Operation
- States:
  - IDLE: go to WAIT when `enable`=1.
  - WAIT: hold here until the interval counter reaches `interval`; with `interval`=0, go to READ on the next cycle.
  - READ: `mem_req`=1, `mem_we`=0; go to RDATA on grant.
  - RDATA: on `mem_rvalid`, capture `mem_rdata` into the word register; go to DECODE.
  - DECODE: one cycle in which the decoder registers the word.
  - EVAL: sample the decoder flags, then take exactly one of these branches:
    - `dec_single` → WRITE.
    - `dec_double` → NEXT.
    - no error → NEXT.
  - WRITE: `mem_req`=1, `mem_we`=1, `mem_wdata` = the `dec_data_out` value captured in EVAL; go to NEXT on grant.
  - NEXT: advance the address and clear the interval counter. Then go to WAIT if `enable`=1, otherwise to IDLE.
- `dec_data_in` is driven continuously from the word register.
- Counting:
  - EVAL with `dec_single`: `sec_count`+1.
  - EVAL with `dec_double`: `ded_count`+1, `ded_flag`←1, `ded_addr`←`mem_addr`.
  - No write-back on a double error.
- Counters saturate at all-ones and never wrap.
- `clr` zeroes `sec_count`, `ded_count`, `ded_flag` and `ded_addr`. If `clr` coincides with an increment, `clr` wins and the result is 0.
- Address:
  - Increments in NEXT.
  - At `DEPTH-1` it wraps to 0 and `pass_done` pulses in that NEXT cycle.
  - It is retained across IDLE, so scrubbing resumes where it stopped.
- `enable` deasserted mid-word: the current word completes through NEXT, including any pending write-back; the FSM then enters IDLE. `enable` is sampled only in IDLE and NEXT.
- `mem_addr` holds the current address in every state; `mem_req` is 0 outside READ and WRITE.

## Timing
- Reset (`rst`=1 at a rising edge):
  - State → IDLE; address, counters, interval counter and word register → 0.
  - Outputs: `mem_req`=0, `mem_we`=0, `mem_wdata`=0, `dec_data_in`=0, `ded_flag`=0, `ded_addr`=0, `pass_done`=0, `busy`=0.
  - A reset in the middle of an access drops `mem_req` in the next cycle; an outstanding `mem_rvalid` is then ignored.
- Decoder latency is fixed at 1 register:
  - `mem_rvalid` in cycle t → word register loaded at the end of t.
  - Decoder samples at the end of t+1.
  - Flags and data are valid and sampled in t+2 (EVAL).
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable from request assertion until the grant cycle inclusive.
- Minimum clean word, with `interval`=0, grant in the same cycle and rvalid one cycle later: WAIT, READ, RDATA, DECODE, EVAL, NEXT = 6 cycles.
- A single-error word adds WRITE (at least 1 cycle).
- Counter updates and `ded_addr` become visible the cycle after EVAL.

## Test plan
- **Clean pass:** `DEPTH`=4, all words error-free, `interval`=0, grant and rvalid immediate → no writes; counts stay 0; `pass_done` pulses once every 24 cycles; address wraps 3→0.
- **Single error:** word 2 has a flipped bit 5 → exactly one write to addr 2 with the corrected codeword; `sec_count`=1.
- **Double error:** word 1 has bits 3 and 40 flipped → no write; `ded_count`=1, `ded_flag`=1, `ded_addr`=1.
- **Saturation and clear:** `CNT_W`=2 with 5 single errors → `sec_count`=3. `clr` pulsed in the same cycle as an EVAL increment → `sec_count`=0.
- **Arbitration and interval:** `mem_gnt` withheld for 7 cycles in READ and in WRITE → request and signals held stable, no duplicate access. With `interval`=3, exactly 3 WAIT cycles precede each READ.
- **Enable and reset mid-pass:**
  - `enable` dropped during RDATA of addr 2 → FSM finishes addr 2, goes IDLE, and resumes at addr 3 when re-enabled.
  - `rst` asserted in WRITE → all outputs return to reset values the next cycle.
